// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with one-hot and binary grant outputs.
// A grant is held until the winner drops its request, or until HOLD_MAX cycles pass while others wait.
module rr_arbiter8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

  state_t     r_state;
  logic [2:0] r_last_idx;
  logic [7:0] r_hold_cnt;
  logic [7:0] r_gnt;
  logic [2:0] r_gnt_idx;
  logic       r_gnt_valid;
  logic       r_preempt;

  logic       w_win_found;
  logic [2:0] w_win_idx;
  logic       w_holder_req;
  logic       w_others_req;
  logic       w_at_limit;

  // Scan starts one past the last winner, so the last winner is tried last.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_win_found = 1'b0;
    w_win_idx   = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      if (!w_win_found && req[r_last_idx + 3'(k)]) begin
        w_win_found = 1'b1;
        w_win_idx   = r_last_idx + 3'(k);
      end
    end
  end

  assign w_holder_req = req[r_gnt_idx];
  assign w_others_req = |(req & ~r_gnt);
  assign w_at_limit   = (HOLD_MAX != 0) && (r_hold_cnt == HOLD_LIMIT);

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last_idx  <= 3'd7;
      r_hold_cnt  <= 8'd0;
      r_gnt       <= 8'd0;
      r_gnt_idx   <= 3'd0;
      r_gnt_valid <= 1'b0;
      r_preempt   <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en && w_win_found) begin
            r_gnt       <= 8'(1) << w_win_idx;
            r_gnt_idx   <= w_win_idx;
            r_gnt_valid <= 1'b1;
            r_last_idx  <= w_win_idx;
            r_hold_cnt  <= 8'd0;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!w_holder_req || (w_at_limit && w_others_req)) begin
            r_gnt       <= 8'd0;
            r_gnt_idx   <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_preempt   <= w_holder_req;
            r_state     <= S_IDLE;
          end else if (!w_at_limit && (r_hold_cnt != 8'hFF)) begin
            // Counter parks at the limit when uncontended so release fires as soon as others appear.
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with HOLD_MAX=4: priority rotation, hold limit,
// enable gating and asynchronous reset, each result compared to hand-computed values.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int checks   = 0;
  int failures = 0;

  rr_arbiter8 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_idx,
                     input logic e_pre);
    check({tag, ".gnt"},       gnt,              e_gnt);
    check({tag, ".gnt_idx"},   {5'd0, gnt_idx},  {5'd0, e_idx});
    check({tag, ".gnt_valid"}, {7'd0, gnt_valid}, {7'd0, (e_gnt != 8'd0)});
    check({tag, ".preempt"},   {7'd0, preempt},  {7'd0, e_pre});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'd0;
    #12;
    chk("reset", 8'h00, 3'd0, 1'b0);

    // Reset priority and full rotation with wrap 7 -> 0.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
    req   = 8'hFF;
    step();
    chk("rot_first", 8'h01, 3'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      req = ~(8'h01 << i);
      step();
      chk($sformatf("rot_rel%0d", i), 8'h00, 3'd0, 1'b0);
      req = 8'hFF;
      step();
      chk($sformatf("rot_gnt%0d", (i + 1) % 8), 8'h01 << ((i + 1) % 8), 3'((i + 1) % 8), 1'b0);
    end
    req = 8'h00;
    step();
    chk("rot_end", 8'h00, 3'd0, 1'b0);

    // Rotation skip: last winner 2, requests on 1 and 7.
    req = 8'h04;
    step();
    chk("skip_set2", 8'h04, 3'd2, 1'b0);
    req = 8'h00;
    step();
    chk("skip_rel2", 8'h00, 3'd0, 1'b0);
    req = 8'h82;
    step();
    chk("skip_gnt7", 8'h80, 3'd7, 1'b0);
    req = 8'h02;
    step();
    chk("skip_rel7", 8'h00, 3'd0, 1'b0);
    req = 8'h82;
    step();
    chk("skip_wrap1", 8'h02, 3'd1, 1'b0);
    req = 8'h00;
    step();
    chk("skip_end", 8'h00, 3'd0, 1'b0);

    // Hold limit of 4 with two contenders: alternating grants separated by preempt.
    req = 8'h03;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk($sformatf("hold_r%0d_c%0d", r, c), 8'h01 << (r % 2), 3'(r % 2), 1'b0);
      end
      step();
      chk($sformatf("hold_pre%0d", r), 8'h00, 3'd0, 1'b1);
    end
    req = 8'h00;
    step();
    chk("hold_end", 8'h00, 3'd0, 1'b0);

    // No contention: grant runs past the limit; a newcomer forces release at once.
    req = 8'h10;
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("solo_c%0d", c), 8'h10, 3'd4, 1'b0);
    end
    req = 8'h11;
    step();
    chk("solo_forced", 8'h00, 3'd0, 1'b1);
    step();
    chk("solo_next", 8'h01, 3'd0, 1'b0);
    req = 8'h00;
    step();
    chk("solo_end", 8'h00, 3'd0, 1'b0);

    // Normal release at the limit with contention wins over forced release.
    req = 8'h03;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("prec_c%0d", c), 8'h02, 3'd1, 1'b0);
    end
    req = 8'h01;
    step();
    chk("prec_rel", 8'h00, 3'd0, 1'b0);
    step();
    chk("prec_next", 8'h01, 3'd0, 1'b0);
    req = 8'h00;
    step();
    chk("prec_end", 8'h00, 3'd0, 1'b0);

    // Enable gating.
    en  = 1'b0;
    req = 8'h08;
    step();
    chk("en_off0", 8'h00, 3'd0, 1'b0);
    step();
    chk("en_off1", 8'h00, 3'd0, 1'b0);
    en = 1'b1;
    step();
    chk("en_on", 8'h08, 3'd3, 1'b0);
    en = 1'b0;
    step();
    chk("en_low_hold0", 8'h08, 3'd3, 1'b0);
    step();
    chk("en_low_hold1", 8'h08, 3'd3, 1'b0);
    req = 8'h00;
    step();
    chk("en_rel", 8'h00, 3'd0, 1'b0);
    en = 1'b1;

    // Asynchronous reset in the middle of a grant with hold count 3.
    req = 8'h20;
    step();
    chk("arst_gnt", 8'h20, 3'd5, 1'b0);
    step();
    step();
    step();
    chk("arst_hold3", 8'h20, 3'd5, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_mid", 8'h00, 3'd0, 1'b0);
    #1;
    rst_n = 1'b1;
    req   = 8'hFF;
    step();
    chk("arst_after", 8'h01, 3'd0, 1'b0);
    req = 8'h00;
    step();
    chk("arst_end", 8'h00, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
